// File: rtl/alu_issue_queue_pkg.sv
// Shared widths, entry layout and readiness helper for the ALU issue queue.
// Entry fields are sized from these constants; the top's width parameters must keep their defaults.
package alu_issue_queue_pkg;

  localparam int PREG_RANGE     = 6;
  localparam int ROB_RANGE      = 7;
  localparam int PC_RANGE       = 48;
  localparam int DATA_RANGE     = 64;
  localparam int SRC_RANGE      = 2;
  localparam int ALU_TYPE_RANGE = 11;

  // Bit position of ADD within the one-hot alu_type vector.
  localparam int ALU_ADD = 0;

  typedef struct packed {
    logic                      valid;
    logic                      src1_rdy;
    logic                      src2_rdy;
    logic [PREG_RANGE-1:0]     prs1;
    logic [PREG_RANGE-1:0]     prs2;
    logic [PREG_RANGE-1:0]     prd;
    logic [ROB_RANGE-1:0]      robidx;
    logic [PC_RANGE-1:0]       pc;
    logic [DATA_RANGE-1:0]     imm;
    logic [ALU_TYPE_RANGE-1:0] alu_type;
    logic                      is_word;
    logic                      is_unsigned;
    logic                      is_imm;
  } alu_iq_entry_t;

  // Preg 0 is the hardwired zero register and never waits on a producer.
  function automatic logic src_ready(input logic flag,
                                     input logic [PREG_RANGE-1:0] prs,
                                     input logic hit);
    return flag | (prs == '0) | hit;
  endfunction

endpackage

// File: rtl/alu_iq_wakeup.sv
// Matches one source preg against every writeback wakeup port.
module alu_iq_wakeup #(
  parameter int NUM_WB = 2,
  parameter int PREG_W = 6
) (
  input  logic [PREG_W-1:0]        prs,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_prd,
  output logic                     hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && (wb_prd[i*PREG_W +: PREG_W] == prs)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting age-ordered issue queue for the integer ALU pipe.
// Entry 0 is the oldest; the oldest ready entry issues and younger entries shift down.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PREG_W     = PREG_RANGE,
  parameter int ROB_W      = ROB_RANGE,
  parameter int NUM_WB     = 2,
  parameter int PC_W       = PC_RANGE,
  parameter int DATA_W     = DATA_RANGE,
  parameter int ALU_TYPE_W = ALU_TYPE_RANGE
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PREG_W-1:0]          enq_prs1,
  input  logic [PREG_W-1:0]          enq_prs2,
  input  logic                       enq_src1_rdy,
  input  logic                       enq_src2_rdy,
  input  logic [PREG_W-1:0]          enq_prd,
  input  logic [ROB_W-1:0]           enq_robidx,
  input  logic [PC_W-1:0]            enq_pc,
  input  logic [DATA_W-1:0]          enq_imm,
  input  logic [ALU_TYPE_W-1:0]      enq_alu_type,
  input  logic                       enq_is_word,
  input  logic                       enq_is_unsigned,
  input  logic                       enq_is_imm,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]   wb_prd,
  input  logic                       flush_valid,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [PREG_W-1:0]          iss_prs1,
  output logic [PREG_W-1:0]          iss_prs2,
  output logic [PREG_W-1:0]          iss_prd,
  output logic [ROB_W-1:0]           iss_robidx,
  output logic [PC_W-1:0]            iss_pc,
  output logic [DATA_W-1:0]          iss_imm,
  output logic [ALU_TYPE_W-1:0]      iss_alu_type,
  output logic                       iss_is_word,
  output logic                       iss_is_unsigned,
  output logic                       iss_is_imm,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  alu_iq_entry_t    entry_reg  [DEPTH];
  alu_iq_entry_t    entry_next [DEPTH];
  alu_iq_entry_t    woke       [DEPTH+1];
  alu_iq_entry_t    enq_entry;
  logic [CNT_W-1:0] count_reg, count_next, enq_slot;
  logic [DEPTH-1:0] wake1, wake2, ready_vec;
  logic             enq_wake1, enq_wake2;
  logic             sel_found, iss_fire, enq_fire;
  logic [IDX_W-1:0] sel_idx;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      alu_iq_wakeup #(.NUM_WB(NUM_WB), .PREG_W(PREG_W)) u_wake1 (
        .prs(entry_reg[gi].prs1), .wb_valid(wb_valid), .wb_prd(wb_prd), .hit(wake1[gi])
      );
      alu_iq_wakeup #(.NUM_WB(NUM_WB), .PREG_W(PREG_W)) u_wake2 (
        .prs(entry_reg[gi].prs2), .wb_valid(wb_valid), .wb_prd(wb_prd), .hit(wake2[gi])
      );
      // Select looks only at registered ready bits, so a wakeup issues one cycle later.
      assign ready_vec[gi] = entry_reg[gi].valid & entry_reg[gi].src1_rdy & entry_reg[gi].src2_rdy;
    end
  endgenerate

  alu_iq_wakeup #(.NUM_WB(NUM_WB), .PREG_W(PREG_W)) u_enq_wake1 (
    .prs(enq_prs1), .wb_valid(wb_valid), .wb_prd(wb_prd), .hit(enq_wake1)
  );
  alu_iq_wakeup #(.NUM_WB(NUM_WB), .PREG_W(PREG_W)) u_enq_wake2 (
    .prs(enq_prs2), .wb_valid(wb_valid), .wb_prd(wb_prd), .hit(enq_wake2)
  );

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign enq_ready = (count_reg < CNT_W'(DEPTH)) & ~flush_valid;
  assign iss_valid = sel_found & ~flush_valid;
  assign iss_fire  = iss_valid & iss_ready;
  assign enq_fire  = enq_valid & enq_ready;
  assign enq_slot  = count_reg - CNT_W'(iss_fire);
  assign count_next = count_reg + CNT_W'(enq_fire) - CNT_W'(iss_fire);
  assign count     = count_reg;

  assign iss_prs1        = entry_reg[sel_idx].prs1;
  assign iss_prs2        = entry_reg[sel_idx].prs2;
  assign iss_prd         = entry_reg[sel_idx].prd;
  assign iss_robidx      = entry_reg[sel_idx].robidx;
  assign iss_pc          = entry_reg[sel_idx].pc;
  assign iss_imm         = entry_reg[sel_idx].imm;
  assign iss_alu_type    = entry_reg[sel_idx].alu_type;
  assign iss_is_word     = entry_reg[sel_idx].is_word;
  assign iss_is_unsigned = entry_reg[sel_idx].is_unsigned;
  assign iss_is_imm      = entry_reg[sel_idx].is_imm;

  always_comb begin
    enq_entry             = '0;
    enq_entry.valid       = 1'b1;
    enq_entry.src1_rdy    = src_ready(enq_src1_rdy, enq_prs1, enq_wake1);
    enq_entry.src2_rdy    = src_ready(enq_src2_rdy, enq_prs2, enq_wake2);
    enq_entry.prs1        = enq_prs1;
    enq_entry.prs2        = enq_prs2;
    enq_entry.prd         = enq_prd;
    enq_entry.robidx      = enq_robidx;
    enq_entry.pc          = enq_pc;
    enq_entry.imm         = enq_imm;
    enq_entry.alu_type    = enq_alu_type;
    enq_entry.is_word     = enq_is_word;
    enq_entry.is_unsigned = enq_is_unsigned;
    enq_entry.is_imm      = enq_is_imm;
  end

  // Wake first, then compact: the slot above the top always reads as empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]          = entry_reg[i];
      woke[i].src1_rdy = entry_reg[i].src1_rdy | wake1[i];
      woke[i].src2_rdy = entry_reg[i].src2_rdy | wake2[i];
    end
    woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && (IDX_W'(i) >= sel_idx)) entry_next[i] = woke[i+1];
      else                                     entry_next[i] = woke[i];
      if (enq_fire && (CNT_W'(i) == enq_slot)) entry_next[i] = enq_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush_valid) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i].valid <= 1'b0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the issue queue.
module tb_alu_issue_queue;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 7;
  localparam int NUM_WB = 2;
  localparam int PC_W   = 48;
  localparam int DATA_W = 64;
  localparam int AT_W   = 11;
  localparam int CNT_W  = 4;
  localparam int PAY_W  = 3*PREG_W + ROB_W + PC_W + DATA_W + AT_W + 3;

  logic clock = 1'b0;
  logic reset_n;
  logic enq_valid, enq_ready, enq_src1_rdy, enq_src2_rdy;
  logic [PREG_W-1:0] enq_prs1, enq_prs2, enq_prd;
  logic [ROB_W-1:0]  enq_robidx;
  logic [PC_W-1:0]   enq_pc;
  logic [DATA_W-1:0] enq_imm;
  logic [AT_W-1:0]   enq_alu_type;
  logic enq_is_word, enq_is_unsigned, enq_is_imm;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*PREG_W-1:0] wb_prd;
  logic flush_valid, iss_valid, iss_ready;
  logic [PREG_W-1:0] iss_prs1, iss_prs2, iss_prd;
  logic [ROB_W-1:0]  iss_robidx;
  logic [PC_W-1:0]   iss_pc;
  logic [DATA_W-1:0] iss_imm;
  logic [AT_W-1:0]   iss_alu_type;
  logic iss_is_word, iss_is_unsigned, iss_is_imm;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ROB_W-1:0] rob_ctr = '0;

  alu_issue_queue #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .NUM_WB(NUM_WB),
    .PC_W(PC_W), .DATA_W(DATA_W), .ALU_TYPE_W(AT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_prd(enq_prd), .enq_robidx(enq_robidx), .enq_pc(enq_pc), .enq_imm(enq_imm),
    .enq_alu_type(enq_alu_type), .enq_is_word(enq_is_word),
    .enq_is_unsigned(enq_is_unsigned), .enq_is_imm(enq_is_imm),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .flush_valid(flush_valid),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_prd(iss_prd),
    .iss_robidx(iss_robidx), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_alu_type(iss_alu_type), .iss_is_word(iss_is_word),
    .iss_is_unsigned(iss_is_unsigned), .iss_is_imm(iss_is_imm),
    .count(count)
  );

  always #5 clock = ~clock;

  // Reference model: an age-ordered list of uops with their source-ready flags.
  typedef struct {
    logic [PREG_W-1:0] prs1, prs2, prd;
    logic [ROB_W-1:0]  rob;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] imm;
    logic [AT_W-1:0]   at;
    logic              w, u, i;
    bit                r1, r2;
  } uop_t;
  uop_t mq[$];

  wire [PAY_W-1:0] dut_pay = {iss_prs1, iss_prs2, iss_prd, iss_robidx, iss_pc, iss_imm,
                              iss_alu_type, iss_is_word, iss_is_unsigned, iss_is_imm};

  function automatic logic [PAY_W-1:0] pay(input uop_t u);
    return {u.prs1, u.prs2, u.prd, u.rob, u.pc, u.imm, u.at, u.w, u.u, u.i};
  endfunction

  function automatic bit woken(input logic [PREG_W-1:0] p);
    for (int k = 0; k < NUM_WB; k++)
      if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel();
    for (int k = 0; k < mq.size(); k++) if (mq[k].r1 && mq[k].r2) return k;
    return -1;
  endfunction

  function automatic bit m_enq_ready();
    return (mq.size() < DEPTH) && !flush_valid;
  endfunction

  function automatic bit m_iss_valid();
    return (m_sel() >= 0) && !flush_valid;
  endfunction

  // Advance the model with the inputs currently driven, then move to the next falling edge.
  task automatic tick();
    uop_t nu;
    bit ef, isf;
    int s;
    if (!reset_n || flush_valid) begin
      mq.delete();
    end else begin
      ef  = enq_valid && m_enq_ready();
      s   = m_sel();
      isf = (s >= 0) && iss_ready;
      nu.prs1 = enq_prs1; nu.prs2 = enq_prs2; nu.prd = enq_prd; nu.rob = enq_robidx;
      nu.pc = enq_pc; nu.imm = enq_imm; nu.at = enq_alu_type;
      nu.w = enq_is_word; nu.u = enq_is_unsigned; nu.i = enq_is_imm;
      nu.r1 = enq_src1_rdy || (enq_prs1 == 0) || woken(enq_prs1);
      nu.r2 = enq_src2_rdy || (enq_prs2 == 0) || woken(enq_prs2);
      if (isf) mq.delete(s);
      foreach (mq[k]) begin
        if (woken(mq[k].prs1)) mq[k].r1 = 1'b1;
        if (woken(mq[k].prs2)) mq[k].r2 = 1'b1;
      end
      if (ef) mq.push_back(nu);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    enq_valid = 1'b0; wb_valid = '0; wb_prd = '0; flush_valid = 1'b0;
  endtask

  task automatic set_enq(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                         input bit r1, input bit r2);
    enq_valid = 1'b1; enq_prs1 = p1; enq_prs2 = p2; enq_src1_rdy = r1; enq_src2_rdy = r2;
    enq_prd = PREG_W'($urandom_range(0, 63));
    enq_robidx = rob_ctr; rob_ctr = rob_ctr + 1'b1;
    enq_pc = PC_W'({$urandom(), $urandom()});
    enq_imm = {$urandom(), $urandom()};
    enq_alu_type = AT_W'(1) << $urandom_range(0, AT_W-1);
    enq_is_word = 1'($urandom_range(0, 1));
    enq_is_unsigned = 1'($urandom_range(0, 1));
    enq_is_imm = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; iss_ready = 1'b0; idle(); set_enq(1, 2, 1, 1);
    tick(); tick();
    reset_n = 1'b1; idle(); #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    tick();
  endtask

  task automatic test_single_issue();
    iss_ready = 1'b1; idle(); set_enq(5, 0, 1, 0); enq_alu_type = AT_W'(1); #1;
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL single_iss_valid: got %b want 1", iss_valid); end
    n_checks++; if (iss_prs1 !== 6'd5) begin n_fail++; $display("FAIL single_prs1: got %0d want 5", iss_prs1); end
    n_checks++; if (iss_alu_type !== AT_W'(1)) begin n_fail++; $display("FAIL single_alu_type: got %h want 001", iss_alu_type); end
    n_checks++; if (mq.size() != 1 || dut_pay !== pay(mq[0])) begin n_fail++; $display("FAIL single_payload: got %h model size %0d", dut_pay, mq.size()); end
    tick(); #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", iss_valid); end
  endtask

  task automatic test_age_order_wakeup();
    logic [ROB_W-1:0] rob_a, rob_b;
    iss_ready = 1'b0; idle();
    set_enq(7, 0, 0, 1); rob_a = enq_robidx; #1; tick();
    set_enq(3, 0, 1, 1); rob_b = enq_robidx; #1; tick();
    idle(); iss_ready = 1'b1; #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_robidx !== rob_b) begin n_fail++; $display("FAIL age_b_first: got v=%b rob=%0d want v=1 rob=%0d", iss_valid, iss_robidx, rob_b); end
    tick(); #1;
    n_checks++; if (count !== 1 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL age_a_waits: got count=%0d v=%b want 1/0", count, iss_valid); end
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd7}; #1;
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL age_no_bypass: got %b want 0", iss_valid); end
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_robidx !== rob_a) begin n_fail++; $display("FAIL age_a_woken: got v=%b rob=%0d want v=1 rob=%0d", iss_valid, iss_robidx, rob_a); end
    tick(); #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL age_drained: got %0d want 0", count); end
  endtask

  task automatic test_enq_wakeup();
    logic [ROB_W-1:0] rob_c;
    iss_ready = 1'b0; idle();
    set_enq(0, 9, 0, 0); rob_c = enq_robidx;
    wb_valid = 2'b10; wb_prd = {6'd9, 6'd0}; #1;
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_robidx !== rob_c) begin n_fail++; $display("FAIL enqwake_ready: got v=%b rob=%0d want v=1 rob=%0d", iss_valid, iss_robidx, rob_c); end
    iss_ready = 1'b1; tick(); #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL enqwake_count: got %0d want 0", count); end
  endtask

  task automatic test_full_and_compact();
    logic [ROB_W-1:0] robs [DEPTH];
    int order [7] = '{0, 1, 2, 4, 5, 6, 7};
    iss_ready = 1'b0; idle();
    for (int k = 0; k < DEPTH; k++) begin
      set_enq(PREG_W'(10 + k), 0, 0, 1); robs[k] = enq_robidx; #1; tick();
    end
    idle(); #1;
    n_checks++; if (count !== 8 || enq_ready !== 1'b0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d rdy=%b v=%b want 8/0/0", count, enq_ready, iss_valid); end
    set_enq(20, 0, 1, 1); #1; tick(); idle(); #1;
    n_checks++; if (count !== 8) begin n_fail++; $display("FAIL full_reject: got %0d want 8", count); end
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd13}; iss_ready = 1'b1; #1; tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_robidx !== robs[3]) begin n_fail++; $display("FAIL full_issue3: got v=%b rob=%0d want v=1 rob=%0d", iss_valid, iss_robidx, robs[3]); end
    tick(); #1;
    n_checks++; if (count !== 7 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_after: got count=%0d rdy=%b want 7/1", count, enq_ready); end
    iss_ready = 1'b0;
    wb_valid = 2'b11; wb_prd = {6'd11, 6'd10}; #1; tick();
    wb_prd = {6'd14, 6'd12}; #1; tick();
    wb_prd = {6'd16, 6'd15}; #1; tick();
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd17}; #1; tick();
    idle(); iss_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_robidx !== robs[order[k]]) begin n_fail++; $display("FAIL full_order%0d: got v=%b rob=%0d want v=1 rob=%0d", k, iss_valid, iss_robidx, robs[order[k]]); end
      tick();
    end
    #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", count); end
  endtask

  task automatic test_hold();
    logic [PAY_W-1:0] exp_pay;
    iss_ready = 1'b0; idle(); set_enq(4, 0, 1, 1); #1; tick(); idle();
    exp_pay = pay(mq[0]);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (iss_valid !== 1'b1 || dut_pay !== exp_pay || count !== 1) begin n_fail++; $display("FAIL hold_c%0d: got v=%b count=%0d pay=%h want 1/1/%h", k, iss_valid, count, dut_pay, exp_pay); end
      tick();
    end
    iss_ready = 1'b1; #1; tick(); #1;
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL hold_release: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    iss_ready = 1'b0; idle();
    for (int k = 0; k < 5; k++) begin
      set_enq(PREG_W'(30 + k), 0, k == 1, 1); #1; tick();
    end
    idle(); #1;
    n_checks++; if (count !== 5 || iss_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got count=%0d v=%b want 5/1", count, iss_valid); end
    set_enq(40, 0, 1, 1); flush_valid = 1'b1; iss_ready = 1'b1; #1;
    n_checks++; if (iss_valid !== 1'b0 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_gate: got v=%b rdy=%b want 0/0", iss_valid, enq_ready); end
    tick(); idle(); #1;
    n_checks++; if (count !== 0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got count=%0d v=%b want 0/0", count, iss_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      set_enq(PREG_W'($urandom_range(0, 15)), PREG_W'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      enq_valid   = $urandom_range(0, 9) < 6;
      wb_valid    = NUM_WB'($urandom_range(0, 3));
      wb_prd      = {PREG_W'($urandom_range(1, 15)), PREG_W'($urandom_range(1, 15))};
      iss_ready   = $urandom_range(0, 9) < 7;
      flush_valid = $urandom_range(0, 49) == 0;
      #1;
      n_checks++; if (count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, mq.size()); end
      n_checks++; if (enq_ready !== m_enq_ready()) begin n_fail++; $display("FAIL rand_enq_ready c%0d: got %b want %b", c, enq_ready, m_enq_ready()); end
      n_checks++; if (iss_valid !== m_iss_valid()) begin n_fail++; $display("FAIL rand_iss_valid c%0d: got %b want %b", c, iss_valid, m_iss_valid()); end
      if (m_iss_valid()) begin
        n_checks++; if (dut_pay !== pay(mq[m_sel()])) begin n_fail++; $display("FAIL rand_payload c%0d: got %h want %h", c, dut_pay, pay(mq[m_sel()])); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    iss_ready = 1'b0; idle();
    for (int k = 0; k < 3; k++) begin
      set_enq(PREG_W'(k), 0, 1, 1); #1; tick();
    end
    reset_n = 1'b0; set_enq(50, 0, 1, 1); #1; tick();
    reset_n = 1'b1; idle(); #1;
    n_checks++; if (count !== 0 || iss_valid !== 1'b0 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL resetmid: got count=%0d v=%b rdy=%b want 0/0/1", count, iss_valid, enq_ready); end
    tick();
  endtask

  initial begin
    reset_n = 1'b0; iss_ready = 1'b0; idle(); set_enq(0, 0, 0, 0); enq_valid = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_issue();
    test_age_order_wakeup();
    test_enq_wakeup();
    test_full_and_compact();
    test_hold();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
